rs422_tx_arbiter: RTL and testbench

Round-robin transmit arbiter that shares one UART/RS422 byte transmitter between two byte-stream requesters. For each frame it grants one requester, prepends a channel-tag header byte, and passes payload bytes through until the requester marks the last byte. A stall timeout releases the grant if a requester stops supplying bytes mid-frame, so the link cannot hang. It sits between the per-channel packet sources and the `uart_tx` byte interface of an RS422 channel.

---
 rtl/rs422_tx_arbiter.sv | 118 +++++++++++
 tb/tb_rs422_tx_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rs422_tx_arbiter.sv
// Round-robin arbiter sharing one RS422 byte transmitter between two requesters.
// Each frame is prefixed with a channel-tag header; a stall timeout aborts dead frames.
module rs422_tx_arbiter #(
    parameter logic [7:0] HDR_BASE       = 8'hA0,
    parameter int         TIMEOUT_CYCLES = 2000
) (
    input  logic        sys_clk,
    input  logic        rst_n,
    input  logic [15:0] req_data,
    input  logic [1:0]  req_valid,
    input  logic [1:0]  req_last,
    output logic [1:0]  req_ready,
    output logic [7:0]  tx_data,
    output logic        tx_data_valid,
    input  logic        tx_data_ready,
    output logic [1:0]  timeout_err,
    output logic [15:0] frame_cnt0,
    output logic [15:0] frame_cnt1
);

    localparam int                IDLE_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HEADER,
        S_PAYLOAD
    } state_e;

    state_e            state_q;
    logic              grant_q;
    logic              last_grant_q;
    logic [IDLE_W-1:0] idle_cnt_q;
    logic [1:0]        timeout_err_q;
    logic [15:0]       frame_cnt0_q;
    logic [15:0]       frame_cnt1_q;

    logic [7:0]        gnt_byte;
    logic              gnt_valid;
    logic              gnt_last;

    always_comb begin
        gnt_byte  = grant_q ? req_data[15:8] : req_data[7:0];
        gnt_valid = req_valid[grant_q];
        gnt_last  = req_last[grant_q];
    end

    // Payload is a zero-latency pass-through of the granted requester.
    always_comb begin
        tx_data       = 8'h00;
        tx_data_valid = 1'b0;
        req_ready     = 2'b00;
        case (state_q)
            S_HEADER: begin
                tx_data       = HDR_BASE | {7'd0, grant_q};
                tx_data_valid = 1'b1;
            end
            S_PAYLOAD: begin
                tx_data       = gnt_byte;
                tx_data_valid = gnt_valid;
                req_ready     = grant_q ? {tx_data_ready, 1'b0} : {1'b0, tx_data_ready};
            end
            default: ;
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            grant_q       <= 1'b0;
            last_grant_q  <= 1'b1;
            idle_cnt_q    <= '0;
            timeout_err_q <= 2'b00;
            frame_cnt0_q  <= 16'd0;
            frame_cnt1_q  <= 16'd0;
        end else begin
            timeout_err_q <= 2'b00;
            case (state_q)
                S_IDLE: begin
                    if (|req_valid) begin
                        grant_q <= (req_valid == 2'b11) ? ~last_grant_q : req_valid[1];
                        state_q <= S_HEADER;
                    end
                end
                S_HEADER: begin
                    if (tx_data_ready) begin
                        idle_cnt_q <= '0;
                        state_q    <= S_PAYLOAD;
                    end
                end
                S_PAYLOAD: begin
                    if (gnt_valid) begin
                        idle_cnt_q <= '0;
                        if (tx_data_ready && gnt_last) begin
                            if (grant_q) frame_cnt1_q <= frame_cnt1_q + 16'd1;
                            else         frame_cnt0_q <= frame_cnt0_q + 16'd1;
                            last_grant_q <= grant_q;
                            state_q      <= S_IDLE;
                        end
                    end else if (idle_cnt_q == IDLE_LAST) begin
                        // Abandoned frame: flag it and hand the link to the other side.
                        timeout_err_q <= grant_q ? 2'b10 : 2'b01;
                        last_grant_q  <= grant_q;
                        state_q       <= S_IDLE;
                    end else begin
                        idle_cnt_q <= idle_cnt_q + IDLE_W'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign timeout_err = timeout_err_q;
    assign frame_cnt0  = frame_cnt0_q;
    assign frame_cnt1  = frame_cnt1_q;

endmodule

// File: tb/tb_rs422_tx_arbiter.sv
// Directed bench for rs422_tx_arbiter: queue-driven sources, an expected-byte
// scoreboard and frame-count model checked every cycle, plus literal checks.
module tb_rs422_tx_arbiter;

    localparam int TO = 8;

    logic        sys_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] req_data = 16'h0000;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  req_last = 2'b00;
    logic [1:0]  req_ready;
    logic [7:0]  tx_data;
    logic        tx_data_valid;
    logic        tx_data_ready = 1'b1;
    logic [1:0]  timeout_err;
    logic [15:0] frame_cnt0;
    logic [15:0] frame_cnt1;

    int tests = 0;
    int fails = 0;

    logic [8:0]  src_q0[$];
    logic [8:0]  src_q1[$];
    logic [7:0]  exp_q[$];
    bit          rdy_seq[$];
    logic [15:0] exp_cnt0 = 16'd0;
    logic [15:0] exp_cnt1 = 16'd0;
    int          to_seen0 = 0;
    int          to_seen1 = 0;
    bit          xfer0 = 1'b0;
    bit          xfer1 = 1'b0;
    bit          stall_v = 1'b0;
    logic [7:0]  stall_d = 8'h00;

    always #5 sys_clk = ~sys_clk;

    rs422_tx_arbiter #(.HDR_BASE(8'hA0), .TIMEOUT_CYCLES(TO)) dut (
        .sys_clk       (sys_clk),
        .rst_n         (rst_n),
        .req_data      (req_data),
        .req_valid     (req_valid),
        .req_last      (req_last),
        .req_ready     (req_ready),
        .tx_data       (tx_data),
        .tx_data_valid (tx_data_valid),
        .tx_data_ready (tx_data_ready),
        .timeout_err   (timeout_err),
        .frame_cnt0    (frame_cnt0),
        .frame_cnt1    (frame_cnt1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Sources: present queue head, advance after an observed handshake.
    always begin
        @(posedge sys_clk);
        #1;
        if (xfer0 && src_q0.size() > 0) src_q0.delete(0);
        if (xfer1 && src_q1.size() > 0) src_q1.delete(0);
        req_valid[0]     = (src_q0.size() > 0);
        req_data[7:0]    = (src_q0.size() > 0) ? src_q0[0][7:0] : 8'h00;
        req_last[0]      = (src_q0.size() > 0) ? src_q0[0][8] : 1'b0;
        req_valid[1]     = (src_q1.size() > 0);
        req_data[15:8]   = (src_q1.size() > 0) ? src_q1[0][7:0] : 8'h00;
        req_last[1]      = (src_q1.size() > 0) ? src_q1[0][8] : 1'b0;
        tx_data_ready    = (rdy_seq.size() > 0) ? rdy_seq.pop_front() : 1'b1;
    end

    // Per-cycle compare against the scoreboard and the frame-count model.
    always @(negedge sys_clk) begin
        xfer0 = 1'b0;
        xfer1 = 1'b0;
        if (!rst_n) begin
            stall_v = 1'b0;
        end else begin
            check("frame_cnt0", frame_cnt0, exp_cnt0);
            check("frame_cnt1", frame_cnt1, exp_cnt1);
            if (stall_v) begin
                check("hold_valid", tx_data_valid, 1);
                check("hold_data", tx_data, stall_d);
            end
            stall_v = tx_data_valid && !tx_data_ready;
            stall_d = tx_data;
            if (tx_data_valid && tx_data_ready) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL tx_byte: got %0h, expected no transfer", tx_data);
                end else begin
                    tests--;
                    check("tx_byte", tx_data, exp_q.pop_front());
                end
            end
            check("ready_onehot", ($countones(req_ready) <= 1), 1);
            if (|req_ready) check("ready_follows_tx", tx_data_ready, 1);
            xfer0 = req_valid[0] && req_ready[0];
            xfer1 = req_valid[1] && req_ready[1];
            if (xfer0) begin
                check("pass_ch0", {tx_data_valid, tx_data}, {1'b1, req_data[7:0]});
                if (req_last[0]) exp_cnt0 = exp_cnt0 + 16'd1;
            end
            if (xfer1) begin
                check("pass_ch1", {tx_data_valid, tx_data}, {1'b1, req_data[15:8]});
                if (req_last[1]) exp_cnt1 = exp_cnt1 + 16'd1;
            end
            if (timeout_err[0]) to_seen0++;
            if (timeout_err[1]) to_seen1++;
        end
    end

    task automatic wait_done(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || src_q0.size() != 0 || src_q1.size() != 0) && n < 200) begin
            @(negedge sys_clk);
            n++;
        end
        tests++;
        if (n >= 200) begin
            fails++;
            $display("FAIL %s: timed out with %0d bytes outstanding, expected 0", name, exp_q.size());
        end
        repeat (3) @(negedge sys_clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0] cap [5];

        // Reset with both requesters already valid.
        src_q0.push_back({1'b1, 8'h55});
        src_q1.push_back({1'b1, 8'h66});
        repeat (3) @(negedge sys_clk);
        check("rst_tx_valid", tx_data_valid, 0);
        check("rst_req_ready", req_ready, 2'b00);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_cnt0", frame_cnt0, 16'd0);
        check("rst_cnt1", frame_cnt1, 16'd0);
        check("rst_timeout", timeout_err, 2'b00);
        rst_n = 1'b1;
        exp_q.push_back(8'hA0); exp_q.push_back(8'h55);
        exp_q.push_back(8'hA1); exp_q.push_back(8'h66);
        @(negedge sys_clk);
        check("first_tie_header", {tx_data_valid, tx_data}, {1'b1, 8'hA0});
        wait_done("reset_frames");
        check("after_reset_cnt0", frame_cnt0, 16'd1);
        check("after_reset_cnt1", frame_cnt1, 16'd1);

        // Single 3-byte frame on channel 1, continuous ready.
        src_q1.push_back({1'b0, 8'h11});
        src_q1.push_back({1'b0, 8'h22});
        src_q1.push_back({1'b1, 8'h33});
        exp_q.push_back(8'hA1); exp_q.push_back(8'h11);
        exp_q.push_back(8'h22); exp_q.push_back(8'h33);
        for (int k = 0; k < 5; k++) begin
            @(negedge sys_clk);
            cap[k] = {tx_data_valid && tx_data_ready, tx_data};
        end
        check("single_c0", cap[0], 9'h000);
        check("single_c1", cap[1], 9'h1A1);
        check("single_c2", cap[2], 9'h111);
        check("single_c3", cap[3], 9'h122);
        check("single_c4", cap[4], 9'h133);
        wait_done("single");
        check("single_cnt1", frame_cnt1, 16'd2);

        // Round robin with both channels continuously loaded.
        src_q0.push_back({1'b0, 8'h01}); src_q0.push_back({1'b1, 8'h02});
        src_q0.push_back({1'b0, 8'h03}); src_q0.push_back({1'b1, 8'h04});
        src_q1.push_back({1'b0, 8'h81}); src_q1.push_back({1'b1, 8'h82});
        src_q1.push_back({1'b0, 8'h83}); src_q1.push_back({1'b1, 8'h84});
        exp_q.push_back(8'hA0); exp_q.push_back(8'h01); exp_q.push_back(8'h02);
        exp_q.push_back(8'hA1); exp_q.push_back(8'h81); exp_q.push_back(8'h82);
        exp_q.push_back(8'hA0); exp_q.push_back(8'h03); exp_q.push_back(8'h04);
        exp_q.push_back(8'hA1); exp_q.push_back(8'h83); exp_q.push_back(8'h84);
        wait_done("round_robin");
        check("rr_cnt0", frame_cnt0, 16'd3);
        check("rr_cnt1", frame_cnt1, 16'd4);

        // Backpressure on a channel-0 frame.
        src_q0.push_back({1'b0, 8'h5A});
        src_q0.push_back({1'b0, 8'h3C});
        src_q0.push_back({1'b1, 8'hC3});
        exp_q.push_back(8'hA0); exp_q.push_back(8'h5A);
        exp_q.push_back(8'h3C); exp_q.push_back(8'hC3);
        for (int k = 0; k < 10; k++) rdy_seq.push_back(k[0] == 1'b0);
        wait_done("backpressure");
        check("bp_cnt0", frame_cnt0, 16'd4);

        // Stall timeout on channel 0 with channel 1 pending.
        src_q0.push_back({1'b0, 8'h77});
        exp_q.push_back(8'hA0); exp_q.push_back(8'h77);
        exp_q.push_back(8'hA1); exp_q.push_back(8'h99);
        for (int k = 1; k <= 13; k++) begin
            @(negedge sys_clk);
            if (k == 4) src_q1.push_back({1'b1, 8'h99});
            if (k == 11) check("to_before", timeout_err, 2'b00);
            if (k == 12) begin
                check("to_pulse", timeout_err, 2'b01);
                check("to_idle_valid", tx_data_valid, 0);
                check("to_idle_ready", req_ready, 2'b00);
            end
            if (k == 13) begin
                check("to_cleared", timeout_err, 2'b00);
                check("to_next_header", {tx_data_valid, tx_data}, {1'b1, 8'hA1});
            end
        end
        wait_done("timeout");
        check("to_cnt0", frame_cnt0, 16'd4);
        check("to_cnt1", frame_cnt1, 16'd5);

        // Counter wrap from a preloaded 0xFFFF.
        @(posedge sys_clk);
        #2;
        force dut.frame_cnt0_q = 16'hFFFF;
        exp_cnt0 = 16'hFFFF;
        #1;
        release dut.frame_cnt0_q;
        @(negedge sys_clk);
        src_q0.push_back({1'b1, 8'hEE});
        src_q1.push_back({1'b1, 8'hDD});
        exp_q.push_back(8'hA0); exp_q.push_back(8'hEE);
        exp_q.push_back(8'hA1); exp_q.push_back(8'hDD);
        wait_done("wrap");
        check("wrap_cnt0", frame_cnt0, 16'd0);
        check("wrap_cnt1", frame_cnt1, 16'd6);
        check("timeouts_ch0", to_seen0, 1);
        check("timeouts_ch1", to_seen1, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
